// File: rtl/pool_pkg.sv
// Shared encodings and sizing helpers for the 2x2 streaming pooling block.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // Index width that stays legal for a single-entry array.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer: holds the reduced even-row pair for each window column k.
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int DW    = 33,
  parameter int KW    = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [KW-1:0] idx_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/pool2d_stream.sv
// 2x2 stride-2 max/average pooling over a raster-order pixel stream with valid gaps.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 6,
  parameter int HEIGHT     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  valid_in,
  input  logic                  mode,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  valid_out,
  output logic                  last_out
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int KW = idx_width(WIDTH / 2);

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  pool_mode_e      mode_q, mode_d, cur_mode;
  logic [DW-1:0]   pair_q, pair_d;
  logic [DW-1:0]   o_data_q, o_data_d;
  logic            valid_q, valid_d, last_q, last_d;

  logic [KW-1:0]   k;
  logic            buf_we;
  logic [DW:0]     buf_rd, pair_red;
  logic [DW-1:0]   pair_max, comb_max, result;
  logic signed [DW+1:0] sum4, sum4_shr;

  assign k = KW'(col_q >> 1);

  pool_line_buf #(.DEPTH(WIDTH / 2), .DW(DW + 1), .KW(KW)) u_line_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .idx_i   (k),
    .wdata_i (pair_red),
    .rdata_o (buf_rd)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    mode_d   = mode_q;
    pair_d   = pair_q;
    o_data_d = o_data_q;
    valid_d  = 1'b0;
    last_d   = 1'b0;

    // The mode sampled with pixel (0,0) governs the whole frame, including that pixel.
    cur_mode = (col_q == '0 && row_q == '0) ? pool_mode_e'(mode) : mode_q;

    pair_max = ($signed(pair_q) > $signed(i_data)) ? pair_q : i_data;
    pair_red = (cur_mode == POOL_AVG) ? ({pair_q[DW-1], pair_q} + {i_data[DW-1], i_data})
                                      : {pair_max[DW-1], pair_max};

    comb_max = ($signed(buf_rd[DW-1:0]) > $signed(pair_red[DW-1:0])) ? buf_rd[DW-1:0]
                                                                     : pair_red[DW-1:0];
    sum4     = {buf_rd[DW], buf_rd} + {pair_red[DW], pair_red};
    sum4_shr = sum4 >>> 2;
    result   = (cur_mode == POOL_AVG) ? sum4_shr[DW-1:0] : comb_max;

    buf_we   = valid_in && col_q[0] && !row_q[0];

    if (valid_in) begin
      if (col_q == '0 && row_q == '0) mode_d = cur_mode;
      if (!col_q[0]) pair_d = i_data;

      if (col_q == CW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      if (col_q[0] && row_q[0]) begin
        valid_d  = 1'b1;
        o_data_d = result;
        last_d   = (col_q == CW'(WIDTH - 1)) && (row_q == RW'(HEIGHT - 1));
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      mode_q   <= POOL_MAX;
      pair_q   <= '0;
      o_data_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      mode_q   <= mode_d;
      pair_q   <= pair_d;
      o_data_q <= o_data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign o_data    = o_data_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream: 4x4 frames at 32 bits plus an 8-bit extremes instance.
module tb_pool2d_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_data;
  logic        valid_in, mode;
  logic [31:0] o_data;
  logic        valid_out, last_out;

  logic [7:0]  d8;
  logic        v8, m8;
  logic [7:0]  o8;
  logic        vo8, lo8;

  int n_cmp = 0;
  int n_bad = 0;
  int frame [4][4];
  int got [$];

  always #5 clk = ~clk;

  pool2d_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_data    (i_data),
    .valid_in  (valid_in),
    .mode      (mode),
    .o_data    (o_data),
    .valid_out (valid_out),
    .last_out  (last_out)
  );

  pool2d_stream #(.DATA_WIDTH(8), .WIDTH(4), .HEIGHT(4)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .i_data    (d8),
    .valid_in  (v8),
    .mode      (m8),
    .o_data    (o8),
    .valid_out (vo8),
    .last_out  (lo8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, $signed(obs), obs,
             $signed(exp), exp);
    end
  endtask

  function automatic int model(input int r2, input int c2, input logic m);
    int a, b, c, d, mx;
    a = frame[2*r2][2*c2];
    b = frame[2*r2][2*c2+1];
    c = frame[2*r2+1][2*c2];
    d = frame[2*r2+1][2*c2+1];
    if (m) return (a + b + c + d) >>> 2;
    mx = a;
    if (b > mx) mx = b;
    if (c > mx) mx = c;
    if (d > mx) mx = d;
    return mx;
  endfunction

  // Streams the 4x4 frame; the mode input switches from m0 to m1 at pixel index sw_idx.
  task automatic run_frame(input logic m0, input logic m1, input int sw_idx,
                           input logic exp_mode, input int max_gap, input string tag);
    int  gaps;
    logic is_out;
    got.delete();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        i_data   = frame[r][c];
        mode     = ((r * 4 + c) >= sw_idx) ? m1 : m0;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        is_out = (r % 2 == 1) && (c % 2 == 1);
        check($sformatf("%s/valid(%0d,%0d)", tag, r, c), {31'd0, valid_out}, {31'd0, is_out});
        check($sformatf("%s/last(%0d,%0d)", tag, r, c), {31'd0, last_out},
              {31'd0, (r == 3 && c == 3)});
        if (is_out) begin
          check($sformatf("%s/data(%0d,%0d)", tag, r, c), o_data, model(r / 2, c / 2, exp_mode));
          got.push_back(o_data);
        end
        gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (gaps) begin
          @(posedge clk);
          #1;
          check($sformatf("%s/gap_valid", tag), {31'd0, valid_out}, 32'd0);
        end
      end
    end
  endtask

  task automatic frame8(input logic [7:0] val, input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      d8 = val;
      m8 = 1'b1;
      v8 = 1'b1;
      @(posedge clk);
      #1;
      v8 = 1'b0;
      if (i == 5 || i == 7 || i == 13 || i == 15) begin
        check($sformatf("%s/valid%0d", tag, i), {31'd0, vo8}, 32'd1);
        check($sformatf("%s/data%0d", tag, i), {{24{o8[7]}}, o8}, {{24{val[7]}}, val});
        check($sformatf("%s/last%0d", tag, i), {31'd0, lo8}, {31'd0, (i == 15)});
      end
    end
  endtask

  initial begin
    rst = 1'b1; i_data = '0; valid_in = 1'b0; mode = 1'b0;
    d8 = '0; v8 = 1'b0; m8 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst/o_data", o_data, 32'd0);
    check("rst/valid_out", {31'd0, valid_out}, 32'd0);
    check("rst/last_out", {31'd0, last_out}, 32'd0);
    check("rst/o8", {24'd0, o8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Max pooling with hand-computed results.
    frame = '{'{1, 5, -3, 2}, '{4, 0, -8, -1}, '{10, 20, 30, 40}, '{-1, -2, -3, -4}};
    run_frame(1'b0, 1'b0, 16, 1'b0, 0, "max");
    check("max/count", got.size(), 32'd4);
    check("max/r0", got[0], 32'd5);
    check("max/r1", got[1], 32'd2);
    check("max/r2", got[2], 32'd20);
    check("max/r3", got[3], 32'd40);

    repeat (3) @(posedge clk);
    #1;
    check("hold/o_data", o_data, 32'd40);
    check("hold/valid_out", {31'd0, valid_out}, 32'd0);

    // Average pooling, same frame: sums 10, -10, 27, 63.
    run_frame(1'b1, 1'b1, 16, 1'b1, 0, "avg");
    check("avg/count", got.size(), 32'd4);
    check("avg/r0", got[0], 32'd2);
    check("avg/r1", got[1], -32'sd3);
    check("avg/r2", got[2], 32'd6);
    check("avg/r3", got[3], 32'd15);

    // Random data with random valid gaps.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        frame[r][c] = int'($urandom_range(0, 2000)) - 1000;
    run_frame(1'b0, 1'b0, 16, 1'b0, 3, "rnd_max");
    check("rnd_max/count", got.size(), 32'd4);
    run_frame(1'b1, 1'b1, 16, 1'b1, 3, "rnd_avg");
    check("rnd_avg/count", got.size(), 32'd4);

    // Back-to-back frames; mode toggles mid-frame 1 at pixel (1,2).
    frame = '{'{-7, 3, 9, -2}, '{6, -5, 1, 8}, '{-3, -8, 11, 4}, '{-1, -6, 2, 13}};
    run_frame(1'b0, 1'b1, 6, 1'b0, 0, "b2b_f1");
    check("b2b_f1/r1", got[1], 32'd9);
    run_frame(1'b1, 1'b1, 16, 1'b1, 0, "b2b_f2");
    check("b2b_f2/r0", got[0], -32'sd1);

    // Reset mid-frame: the partial frame is discarded.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      i_data = 32'(100 + i); mode = 1'b0; valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst/o_data", o_data, 32'd0);
    check("midrst/valid_out", {31'd0, valid_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    frame = '{'{2, 4, 6, 8}, '{1, 3, 5, 7}, '{-2, -4, -6, -8}, '{-1, -3, -5, -7}};
    run_frame(1'b1, 1'b1, 16, 1'b1, 0, "postrst");
    check("postrst/count", got.size(), 32'd4);
    check("postrst/r3", got[3], -32'sd7);

    // 8-bit extremes in average mode.
    frame8(8'd127, "ext_pos");
    frame8(8'h80, "ext_neg");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pool2d_stream.md
POOL2D_STREAM -- requirements
Module: pool2d_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: signed two's-complement sample width.
REQ-002 SHALL have parameter WIDTH, default 6: feature-map columns; even, >= 2.
REQ-003 SHALL have parameter HEIGHT, default 6: feature-map rows; even, >= 2.
REQ-004 SHALL have port clk  input  1: single clock; all state rising-edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port i_data  input  DATA_WIDTH: raster-order pixel, row-major.
REQ-007 SHALL have port valid_in  input  1: i_data valid this cycle; gaps allowed.
REQ-008 SHALL have port mode  input  1: 0 = max pooling, 1 = average pooling.
REQ-009 SHALL have port o_data  output  DATA_WIDTH: pooled result.
REQ-010 SHALL have port valid_out  output  1: o_data valid, one-cycle pulse per result.
REQ-011 SHALL have port last_out  output  1: high with valid_out on the final result of a frame.

Function
REQ-012 SHALL perform 2x2 pooling, stride 2: one result per window, (WIDTH/2)*(HEIGHT/2) results per frame.
REQ-013 SHALL generate all window control internally from col/row counters; no external strobes.
REQ-014 SHALL advance col only on valid_in; col wraps WIDTH-1 -> 0 and increments row; row wraps HEIGHT-1 -> 0 (frame end).
REQ-015 SHALL latch mode when valid_in is accepted at col=0, row=0; mode changes mid-frame are ignored until the next frame.
REQ-016 SHALL on even rows reduce each horizontal pair (cols 2k, 2k+1) and store it in line-buffer entry k (WIDTH/2 entries).
REQ-017 SHALL store max(a,b) in max mode; a+b at DATA_WIDTH+1 bits in avg mode.
REQ-018 SHALL on odd rows reduce the pair the same way and combine it with entry k: max of both, or sum of both at DATA_WIDTH+2 bits.
REQ-019 SHALL compute avg result as arithmetic right shift by 2 of the 4-sample sum (floor), truncated to DATA_WIDTH; no overflow possible.
REQ-020 SHALL hold the even-column sample of a pair in a register until its odd partner arrives, across any valid_in gaps.
REQ-021 SHALL register o_data; valid_out asserts exactly 1 cycle after the cycle accepting an odd-row, odd-column pixel.
REQ-022 SHALL assert last_out only with the result of row HEIGHT-1, col WIDTH-1.
REQ-023 SHALL hold o_data at its last value when valid_out is low.
REQ-024 SHALL accept back-to-back frames with no idle cycle; entry reuse is safe because row 2j+1 reads entry k before row 2j+2 overwrites it.
REQ-025 SHALL compare signed values (max(-3,-8) = -3).

Reset
REQ-026 SHALL on rst drive o_data=0, valid_out=0, last_out=0, col=0, row=0, latched mode=0, pair register=0.
REQ-027 SHALL NOT require line-buffer contents to be cleared; they SHALL be written before being read.
REQ-028 SHALL on rst mid-frame discard the partial frame; the first valid_in after release is pixel (0,0).

Structure
REQ-029 SHALL place mode encodings POOL_MAX=1'b0 and POOL_AVG=1'b1 in shared package pool_pkg.
REQ-030 SHALL implement the WIDTH/2-entry, DATA_WIDTH+1-bit buffer as sub-module pool_line_buf (one write port, one read port, same index k).
REQ-031 SHALL use counter widths $clog2(WIDTH) and $clog2(HEIGHT).

Verification (WIDTH=4, HEIGHT=4 unless stated)
REQ-032 Max: row0 = 1,5,-3,2; row1 = 4,0,-8,-1 -> o_data 5, then 2, each valid_out 1 cycle after col1 and col3 of row1.
REQ-033 Avg: same rows, mode=1 -> o_data 2, then -3 (sum -10 floors to -3).
REQ-034 Full 4x4 frame with random valid_in gaps -> exactly 4 results equal to the software model; last_out only on the 4th.
REQ-035 Two frames back-to-back, mode=0 then toggled to 1 at frame-1 pixel (1,2) -> frame 1 all max, frame 2 all avg.
REQ-036 rst pulsed after 6 pixels of frame 1 -> no output from the partial frame; next 16 pixels give a correct frame with last_out on the 4th result.
REQ-037 Extremes, DATA_WIDTH=8, avg: all four = 127 -> 127; all four = -128 -> -128 (no wrap).
